// File: rtl/afifo_wr_arbiter_if.sv
// Requester-side handshake and FIFO write-port bundle for afifo_wr_arbiter.
// The arbiter uses the slave modport; the requester/FIFO environment uses master.
interface afifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) ();
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_write;
    logic [ID_W+DATA_WIDTH-1:0]    fifo_data;
    logic [ID_W-1:0]               grant_id;

    modport master (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_write, fifo_data, grant_id
    );

    modport slave (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_write, fifo_data, grant_id
    );
endinterface

// File: rtl/afifo_wr_arbiter.sv
// Round-robin arbiter sharing one afifo_channel write port among NUM_REQ requesters.
// Optional burst lock: define AFIFO_ARB_BURST_LOCK_EN to hold a winner for up to MAX_BURST beats.
module afifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int MAX_BURST  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    afifo_wr_arbiter_if.slave    bus
);
    if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_param
        $error("afifo_wr_arbiter: parameter out of range");
    end

    logic [ID_W-1:0]       last;
    logic [ID_W-1:0]       win;
    logic                  found;
    logic [DATA_WIDTH-1:0] win_data;
    logic [NUM_REQ-1:0]    rdy;
    logic                  xfer;

`ifdef AFIFO_ARB_BURST_LOCK_EN
    typedef enum logic {IDLE, LOCKED} state_t;
    localparam logic [7:0] MAX_B = 8'(MAX_BURST);
    state_t     state;
    logic [7:0] cnt;
`endif

    always_comb begin
        logic [ID_W-1:0] idx;
        idx   = '0;
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(last) + k) % NUM_REQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
`ifdef AFIFO_ARB_BURST_LOCK_EN
        // While locked the owner is always 'last'; it overrides rotation only while still valid.
        if (state == LOCKED && bus.req_valid[last]) begin
            found = 1'b1;
            win   = last;
        end
`endif
    end

    always_comb begin
        rdy      = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rdy[i] = found && !bus.fifo_full && (ID_W'(i) == win);
            if (ID_W'(i) == win) win_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign bus.req_ready = rdy;
    assign xfer          = |(bus.req_valid & rdy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.fifo_write <= 1'b0;
            bus.fifo_data  <= '0;
            bus.grant_id   <= '0;
            last           <= ID_W'(NUM_REQ - 1);
`ifdef AFIFO_ARB_BURST_LOCK_EN
            state          <= IDLE;
            cnt            <= '0;
`endif
        end else if (xfer) begin
            bus.fifo_write <= 1'b1;
            bus.fifo_data  <= {win, win_data};
            bus.grant_id   <= win;
            last           <= win;
`ifdef AFIFO_ARB_BURST_LOCK_EN
            if (state == LOCKED && win == last) begin
                if (cnt + 8'd1 == MAX_B) state <= IDLE;
                else                     cnt   <= cnt + 8'd1;
            end else if (MAX_BURST > 1) begin
                state <= LOCKED;
                cnt   <= 8'd1;
            end else begin
                state <= IDLE;
            end
`endif
        end else begin
            bus.fifo_write <= 1'b0;
`ifdef AFIFO_ARB_BURST_LOCK_EN
            // A stall keeps the lock; only the owner going idle releases it.
            if (state == LOCKED && !bus.req_valid[last]) state <= IDLE;
`endif
        end
    end
endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Scoreboard bench for afifo_wr_arbiter: stimulus pushes expected writes, a monitor pops them.
module tb_afifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    afifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_W(IW)) bus ();

    afifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_W(IW), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [IW+DW-1:0] exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Monitor: every registered write must match the oldest expected beat.
    initial forever begin
        logic [IW+DW-1:0] e;
        @(negedge clk);
        if (rst_n && bus.fifo_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%h expected=none", bus.fifo_data);
            end else begin
                e = exp_q.pop_front();
                chk("fifo_data", bus.fifo_data, e);
                chk("grant_id", bus.grant_id, e[IW+DW-1:DW]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    // One cycle: check req_ready mid-cycle, queue the beat it should accept, advance.
    task automatic step(input logic [N-1:0] exp_rdy, input string nm);
        @(negedge clk);
        chk({"req_ready_", nm}, bus.req_ready, exp_rdy);
        for (int i = 0; i < N; i++)
            if (exp_rdy[i]) exp_q.push_back({IW'(i), bus.req_data[i*DW +: DW]});
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [31:0] base);
        for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = base + 32'(i);
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_fifo_write", bus.fifo_write, 0);
        chk("rst_fifo_data", bus.fifo_data, 0);
        chk("rst_grant_id", bus.grant_id, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First grants after reset, all requesters valid
        set_data(32'hA000_0000);
        bus.req_valid = 4'b1111;
`ifdef AFIFO_ARB_BURST_LOCK_EN
        repeat (4) step(4'b0001, "lock0");
        step(4'b0010, "lock1");
`else
        step(4'b0001, "rr0");
        step(4'b0010, "rr1");
        step(4'b0100, "rr2");
        step(4'b1000, "rr3");
        step(4'b0001, "rr4");
`endif
        bus.req_valid = '0;
        step(4'b0000, "idle1");

        // Single requester 2, changing payload every beat
        bus.req_valid = 4'b0100;
        for (int k = 0; k < 32; k++) begin
            bus.req_data[2*DW +: DW] = 32'hCAFE_0000 + 32'(k);
            step(4'b0100, "single2");
        end
        bus.req_valid = '0;
        step(4'b0000, "idle2");
        @(negedge clk);
        chk("idle_no_write", bus.fifo_write, 0);
        @(posedge clk);
        #1;

        // Backpressure mid-stream (last = 2)
        set_data(32'hB000_0000);
        bus.req_valid = 4'b1111;
`ifdef AFIFO_ARB_BURST_LOCK_EN
        step(4'b1000, "bp_a");
        step(4'b1000, "bp_b");
`else
        step(4'b1000, "bp_a");
        step(4'b0001, "bp_b");
`endif
        bus.fifo_full = 1'b1;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("stall_ready", bus.req_ready, 0);
            if (s >= 1) chk("stall_write", bus.fifo_write, 0);
            @(posedge clk);
            #1;
        end
        bus.fifo_full = 1'b0;
`ifdef AFIFO_ARB_BURST_LOCK_EN
        step(4'b1000, "bp_c");
        step(4'b1000, "bp_d");
        step(4'b0001, "bp_e");
`else
        step(4'b0010, "bp_c");
        step(4'b0100, "bp_d");
        step(4'b1000, "bp_e");
`endif
        bus.req_valid = '0;
        step(4'b0000, "idle3");

        // Reset mid-stream from requester 1
        bus.req_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            bus.req_data[1*DW +: DW] = 32'hD000_0000 + 32'(k);
            step(4'b0010, "pre_rst");
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_write", bus.fifo_write, 0);
        chk("async_rst_data", bus.fifo_data, 0);
        chk("async_rst_grant", bus.grant_id, 0);
        set_data(32'hE000_0000);
        bus.req_valid = 4'b1111;
        @(posedge clk);
        #1;
        chk("held_rst_write", bus.fifo_write, 0);
        rst_n = 1'b1;

        // Rotation vs. burst lock after reset
`ifdef AFIFO_ARB_BURST_LOCK_EN
        repeat (4) step(4'b0001, "burst0");
        step(4'b0010, "burst1a");
        step(4'b0010, "burst1b");
        bus.req_valid = 4'b1101;
        step(4'b0100, "burst_drop");
`else
        step(4'b0001, "post_rst0");
        step(4'b0010, "post_rst1");
        step(4'b0100, "post_rst2");
        step(4'b1000, "post_rst3");
`endif
        bus.req_valid = '0;
        step(4'b0000, "idle4");
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
